sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_resp_pkg.sv | 57 +++++
 rtl/sram_responder_if.sv | 26 ++
 rtl/sram_byte_ram.sv | 40 ++++
 rtl/sram_responder.sv | 120 ++++++++++++
 tb/tb_sram_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_resp_pkg.sv
// Shared constants, types and helpers for the SRAM responder.
// The optional free-running timer is enabled by defining SRAM_RESP_TIMER_EN.
package sram_resp_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned LaneW    = 8;
  localparam int unsigned NumLanes = DataW / LaneW;

  // addr[31:16] value that selects the config region
  localparam logic [15:0] ConfHiDefault = 16'hbfaf;

  // Config register byte offsets (addr[15:0])
  localparam logic [15:0] OffLed    = 16'h0000;
  localparam logic [15:0] OffSwitch = 16'h0004;
  localparam logic [15:0] OffNum    = 16'h0008;
  localparam logic [15:0] OffTimer  = 16'he000;

  typedef enum logic [2:0] {
    CfgLed,
    CfgSwitch,
    CfgNum,
    CfgTimer,
    CfgBad
  } cfg_reg_e;

  // Replace the lanes of old_val selected by wen with the same lanes of new_val
  function automatic logic [DataW-1:0] lane_merge(input logic [DataW-1:0]    old_val,
                                                  input logic [DataW-1:0]    new_val,
                                                  input logic [NumLanes-1:0] wen);
    logic [DataW-1:0] res;
    res = old_val;
    for (int i = 0; i < NumLanes; i++) begin
      if (wen[i]) res[i*LaneW +: LaneW] = new_val[i*LaneW +: LaneW];
    end
    return res;
  endfunction

  // Decode a config word offset (addr[15:2]); byte offset bits are ignored
  function automatic cfg_reg_e cfg_decode(input logic [13:0] word_off);
    cfg_reg_e res;
    if (word_off == OffLed[15:2]) begin
      res = CfgLed;
    end else if (word_off == OffSwitch[15:2]) begin
      res = CfgSwitch;
    end else if (word_off == OffNum[15:2]) begin
      res = CfgNum;
`ifdef SRAM_RESP_TIMER_EN
    end else if (word_off == OffTimer[15:2]) begin
      res = CfgTimer;
`endif
    end else begin
      res = CfgBad;
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Bus bundle between a requester (master) and the SRAM responder (slave),
// including the board-level switch input and LED/display/error outputs.
interface sram_responder_if;
  import sram_resp_pkg::*;

  logic                en;
  logic [NumLanes-1:0] wen;
  logic [DataW-1:0]    addr;
  logic [DataW-1:0]    wdata;
  logic [DataW-1:0]    rdata;
  logic [7:0]          switch_in;
  logic [15:0]         led;
  logic [DataW-1:0]    num;
  logic                bad_access;

  modport master (
    output en, wen, addr, wdata, switch_in,
    input  rdata, led, num, bad_access
  );

  modport slave (
    input  en, wen, addr, wdata, switch_in,
    output rdata, led, num, bad_access
  );

endinterface

// File: rtl/sram_byte_ram.sv
// 2^AW x 32 RAM with per-byte write enables and a registered, read-first
// output. Contents are not reset; only the output register is.
module sram_byte_ram
  import sram_resp_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [NumLanes-1:0] i_wen,
  input  logic [AW-1:0]       i_addr,
  input  logic [DataW-1:0]    i_wdata,
  output logic [DataW-1:0]    o_rdata
);

  logic [DataW-1:0] r_mem [0:(1<<AW)-1];
  logic [DataW-1:0] r_rdata;

  // Byte-lane writes; anything presented while rst is high is dropped
  always_ff @(posedge clk) begin
    if (i_en && !rst) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (i_wen[i]) r_mem[i_addr][i*LaneW +: LaneW] <= i_wdata[i*LaneW +: LaneW];
      end
    end
  end

  // Read-first output register; holds while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_responder.sv
// SRAM responder: word-addressed RAM plus a small config register block
// (LED, switches, display number, optional timer) selected by addr[31:16].
// Define SRAM_RESP_TIMER_EN to build the free-running timer at offset 0xE000;
// without it that offset is unmapped like any other unknown config offset.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int unsigned RAM_AW  = 12,
  parameter logic [15:0] CONF_HI = ConfHiDefault
) (
  input  logic            clk,
  input  logic            reset,
  sram_responder_if.slave bus
);

  logic             w_cfg_sel;
  logic             w_cfg_acc;
  logic             w_ram_en;
  cfg_reg_e         w_cfg_reg;
  logic [DataW-1:0] w_cfg_rdata;
  logic [DataW-1:0] w_ram_rdata;
  logic             w_unused_addr;

  logic             r_cfg_sel;
  logic [DataW-1:0] r_cfg_rdata;
  logic [15:0]      r_led;
  logic [DataW-1:0] r_num;
  logic             r_bad;

`ifdef SRAM_RESP_TIMER_EN
  logic [DataW-1:0] r_timer;
`endif

  assign w_cfg_sel     = (bus.addr[31:16] == CONF_HI);
  assign w_cfg_acc     = bus.en && w_cfg_sel;
  assign w_ram_en      = bus.en && !w_cfg_sel;
  assign w_cfg_reg     = cfg_decode(bus.addr[15:2]);
  // Byte offset within a word has no meaning here
  assign w_unused_addr = ^bus.addr[1:0];

  sram_byte_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .i_en    (w_ram_en),
    .i_wen   (bus.wen),
    .i_addr  (bus.addr[RAM_AW+1:2]),
    .i_wdata (bus.wdata),
    .o_rdata (w_ram_rdata)
  );

  // Config read value from current (pre-edge) register contents
  always_comb begin
    w_cfg_rdata = '0;
    case (w_cfg_reg)
      CfgLed:    w_cfg_rdata = {16'h0000, r_led};
      CfgSwitch: w_cfg_rdata = {24'h000000, bus.switch_in};
      CfgNum:    w_cfg_rdata = r_num;
`ifdef SRAM_RESP_TIMER_EN
      CfgTimer:  w_cfg_rdata = r_timer;
`endif
      default:   w_cfg_rdata = '0;
    endcase
  end

  // Registered config read data and region select for the output mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg_sel   <= 1'b0;
      r_cfg_rdata <= '0;
    end else if (bus.en) begin
      r_cfg_sel <= w_cfg_sel;
      if (w_cfg_sel) r_cfg_rdata <= w_cfg_rdata;
    end
  end

  // LED (lanes 0-1 only) and NUM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= '0;
      r_num <= '0;
    end else if (w_cfg_acc) begin
      if (w_cfg_reg == CfgLed) begin
        for (int i = 0; i < 2; i++) begin
          if (bus.wen[i]) r_led[i*LaneW +: LaneW] <= bus.wdata[i*LaneW +: LaneW];
        end
      end
      if (w_cfg_reg == CfgNum) r_num <= lane_merge(r_num, bus.wdata, bus.wen);
    end
  end

  // Sticky flag for any access to an unmapped config offset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bad <= 1'b0;
    end else if (w_cfg_acc && (w_cfg_reg == CfgBad)) begin
      r_bad <= 1'b1;
    end
  end

`ifdef SRAM_RESP_TIMER_EN
  // Free-running timer; a TIMER write wins over that cycle's increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_cfg_acc && (w_cfg_reg == CfgTimer)) begin
      r_timer <= lane_merge(r_timer, bus.wdata, bus.wen);
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end
`endif

  assign bus.rdata      = r_cfg_sel ? r_cfg_rdata : w_ram_rdata;
  assign bus.led        = r_led;
  assign bus.num        = r_num;
  assign bus.bad_access = r_bad;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder. Expected read data is pushed to a
// scoreboard queue when an access is driven and popped after the edge.
module tb_sram_responder;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    logic [7:0]  sw;
  } op_t;

  logic clk;
  logic reset;

  sram_responder_if bus_if ();

  sram_responder #(
    .RAM_AW  (12),
    .CONF_HI (16'hbfaf)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] sb_q[$];
  logic [31:0] model[int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic chk, input logic [31:0] exp);
    bus_if.en    = 1'b1;
    bus_if.wen   = wen;
    bus_if.addr  = addr;
    bus_if.wdata = wdata;
    sb_q.push_back({chk, exp});
  endtask

  task automatic idle();
    bus_if.en  = 1'b0;
    bus_if.wen = 4'h0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_checks += 4;
    if (bus_if.rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want %h", bus_if.rdata, 32'h0);
    end
    if (bus_if.led !== 16'h0) begin
      n_fail++; $display("FAIL reset_led: got %h want %h", bus_if.led, 16'h0);
    end
    if (bus_if.num !== 32'h0) begin
      n_fail++; $display("FAIL reset_num: got %h want %h", bus_if.num, 32'h0);
    end
    if (bus_if.bad_access !== 1'b0) begin
      n_fail++; $display("FAIL reset_bad: got %b want 0", bus_if.bad_access);
    end
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_ram_rw();
    op_t ops[$];
    logic [32:0] item;
    ops.push_back('{4'hf, 32'h10,   32'h1122_3344, 1'b0, 32'h0,          8'h00});
    ops.push_back('{4'h0, 32'h10,   32'h0,         1'b1, 32'h1122_3344, 8'h00});
    ops.push_back('{4'h5, 32'h10,   32'hAABB_CCDD, 1'b1, 32'h1122_3344, 8'h00});
    ops.push_back('{4'h0, 32'h10,   32'h0,         1'b1, 32'h11BB_33DD, 8'h00});
    ops.push_back('{4'h0, 32'h4010, 32'h0,         1'b1, 32'h11BB_33DD, 8'h00});
    foreach (ops[i]) begin
      bus_if.switch_in = ops[i].sw;
      drive(ops[i].wen, ops[i].addr, ops[i].wdata, ops[i].chk, ops[i].exp);
      step();
      item = sb_q.pop_front();
      if (item[32]) begin
        n_checks++;
        if (bus_if.rdata !== item[31:0]) begin
          n_fail++; $display("FAIL ram_rw[%0d]: got %h want %h", i, bus_if.rdata, item[31:0]);
        end
      end
    end
    // Idle with a write pattern on the bus: nothing may change
    idle();
    bus_if.wen   = 4'hf;
    bus_if.addr  = 32'h10;
    bus_if.wdata = 32'hDEAD_DEAD;
    step();
    step();
    n_checks++;
    if (bus_if.rdata !== 32'h11BB_33DD) begin
      n_fail++; $display("FAIL ram_hold: got %h want %h", bus_if.rdata, 32'h11BB_33DD);
    end
    idle();
  endtask

  task automatic test_read_first();
    op_t ops[$];
    logic [32:0] item;
    ops.push_back('{4'hf, 32'h10, 32'h0, 1'b1, 32'h11BB_33DD, 8'h00});
    ops.push_back('{4'h0, 32'h10, 32'h0, 1'b1, 32'h0,         8'h00});
    foreach (ops[i]) begin
      drive(ops[i].wen, ops[i].addr, ops[i].wdata, ops[i].chk, ops[i].exp);
      step();
      item = sb_q.pop_front();
      if (item[32]) begin
        n_checks++;
        if (bus_if.rdata !== item[31:0]) begin
          n_fail++; $display("FAIL read_first[%0d]: got %h want %h", i, bus_if.rdata, item[31:0]);
        end
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [32:0] item;
    logic [31:0] d;
    logic [31:0] m;
    logic [3:0]  w;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model[i] = d;
      drive(4'hf, 32'h200 + 32'(4 * i), d, 1'b0, 32'h0);
      step();
      item = sb_q.pop_front();
    end
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      w = 4'($urandom_range(1, 15));
      m = model[i];
      drive(w, 32'h200 + 32'(4 * i), d, 1'b1, m);
      for (int b = 0; b < 4; b++) begin
        if (w[b]) m[b*8 +: 8] = d[b*8 +: 8];
      end
      model[i] = m;
      step();
      item = sb_q.pop_front();
      if (item[32]) begin
        n_checks++;
        if (bus_if.rdata !== item[31:0]) begin
          n_fail++; $display("FAIL b2b_wr[%0d]: got %h want %h", i, bus_if.rdata, item[31:0]);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(4'h0, 32'h200 + 32'(4 * i), 32'h0, 1'b1, model[i]);
      step();
      item = sb_q.pop_front();
      if (item[32]) begin
        n_checks++;
        if (bus_if.rdata !== item[31:0]) begin
          n_fail++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, bus_if.rdata, item[31:0]);
        end
      end
    end
    idle();
  endtask

  task automatic test_config();
    op_t ops[$];
    logic [32:0] item;
    ops.push_back('{4'hf, 32'hbfaf_0000, 32'hFFFF_1234, 1'b1, 32'h0,         8'h5A});
    ops.push_back('{4'h0, 32'hbfaf_0000, 32'h0,         1'b1, 32'h0000_1234, 8'h5A});
    ops.push_back('{4'h0, 32'hbfaf_0004, 32'h0,         1'b1, 32'h0000_005A, 8'h5A});
    ops.push_back('{4'hf, 32'hbfaf_0006, 32'hFFFF_FFFF, 1'b1, 32'h0000_005A, 8'h5A});
    ops.push_back('{4'hf, 32'hbfaf_0008, 32'hDEAD_BEEF, 1'b1, 32'h0,         8'h5A});
    ops.push_back('{4'h8, 32'hbfaf_0008, 32'h1100_0000, 1'b1, 32'hDEAD_BEEF, 8'h5A});
    ops.push_back('{4'h0, 32'hbfaf_0008, 32'h0,         1'b1, 32'h11AD_BEEF, 8'hC3});
    ops.push_back('{4'h0, 32'hbfaf_0004, 32'h0,         1'b1, 32'h0000_00C3, 8'hC3});
    foreach (ops[i]) begin
      bus_if.switch_in = ops[i].sw;
      drive(ops[i].wen, ops[i].addr, ops[i].wdata, ops[i].chk, ops[i].exp);
      step();
      item = sb_q.pop_front();
      if (item[32]) begin
        n_checks++;
        if (bus_if.rdata !== item[31:0]) begin
          n_fail++; $display("FAIL config[%0d]: got %h want %h", i, bus_if.rdata, item[31:0]);
        end
      end
    end
    idle();
    n_checks += 3;
    if (bus_if.led !== 16'h1234) begin
      n_fail++; $display("FAIL cfg_led: got %h want %h", bus_if.led, 16'h1234);
    end
    if (bus_if.num !== 32'h11AD_BEEF) begin
      n_fail++; $display("FAIL cfg_num: got %h want %h", bus_if.num, 32'h11AD_BEEF);
    end
    if (bus_if.bad_access !== 1'b0) begin
      n_fail++; $display("FAIL cfg_bad: got %b want 0", bus_if.bad_access);
    end
  endtask

  task automatic test_timer();
    logic [32:0] item;
`ifdef SRAM_RESP_TIMER_EN
    drive(4'hf, 32'hbfaf_e000, 32'h0000_0100, 1'b0, 32'h0);
    step();
    item = sb_q.pop_front();
    idle();
    step();
    step();
    drive(4'h0, 32'hbfaf_e000, 32'h0, 1'b1, 32'h0000_0102);
    step();
    item = sb_q.pop_front();
    n_checks += 2;
    if (bus_if.rdata !== item[31:0]) begin
      n_fail++; $display("FAIL timer: got %h want %h", bus_if.rdata, item[31:0]);
    end
    if (bus_if.bad_access !== 1'b0) begin
      n_fail++; $display("FAIL timer_bad: got %b want 0", bus_if.bad_access);
    end
`else
    drive(4'hf, 32'hbfaf_e000, 32'h0000_0100, 1'b1, 32'h0);
    step();
    item = sb_q.pop_front();
    n_checks += 2;
    if (bus_if.rdata !== item[31:0]) begin
      n_fail++; $display("FAIL timer_off: got %h want %h", bus_if.rdata, item[31:0]);
    end
    if (bus_if.bad_access !== 1'b1) begin
      n_fail++; $display("FAIL timer_off_bad: got %b want 1", bus_if.bad_access);
    end
`endif
    idle();
  endtask

  task automatic test_bad_access();
    logic [32:0] item;
    drive(4'hf, 32'hbfaf_0040, 32'hFFFF_FFFF, 1'b1, 32'h0);
    step();
    item = sb_q.pop_front();
    n_checks += 2;
    if (bus_if.rdata !== item[31:0]) begin
      n_fail++; $display("FAIL bad_rdata: got %h want %h", bus_if.rdata, item[31:0]);
    end
    if (bus_if.bad_access !== 1'b1) begin
      n_fail++; $display("FAIL bad_set: got %b want 1", bus_if.bad_access);
    end
    drive(4'h0, 32'h10, 32'h0, 1'b1, 32'h0);
    step();
    item = sb_q.pop_front();
    idle();
    step();
    step();
    n_checks += 4;
    if (bus_if.rdata !== item[31:0]) begin
      n_fail++; $display("FAIL bad_ram_rd: got %h want %h", bus_if.rdata, item[31:0]);
    end
    if (bus_if.bad_access !== 1'b1) begin
      n_fail++; $display("FAIL bad_sticky: got %b want 1", bus_if.bad_access);
    end
    if (bus_if.num !== 32'h11AD_BEEF) begin
      n_fail++; $display("FAIL bad_num: got %h want %h", bus_if.num, 32'h11AD_BEEF);
    end
    if (bus_if.led !== 16'h1234) begin
      n_fail++; $display("FAIL bad_led: got %h want %h", bus_if.led, 16'h1234);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [32:0] item;
    drive(4'h0, 32'h200, 32'h0, 1'b1, model[0]);
    step();
    item = sb_q.pop_front();
    n_checks++;
    if (bus_if.rdata !== item[31:0]) begin
      n_fail++; $display("FAIL mid_read: got %h want %h", bus_if.rdata, item[31:0]);
    end
    // Second read in flight, reset lands before its edge
    drive(4'h0, 32'h204, 32'h0, 1'b0, 32'h0);
    item = sb_q.pop_front();
    #2 reset = 1'b1;
    #1;
    n_checks += 4;
    if (bus_if.rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata: got %h want %h", bus_if.rdata, 32'h0);
    end
    if (bus_if.led !== 16'h0) begin
      n_fail++; $display("FAIL rst_led: got %h want %h", bus_if.led, 16'h0);
    end
    if (bus_if.num !== 32'h0) begin
      n_fail++; $display("FAIL rst_num: got %h want %h", bus_if.num, 32'h0);
    end
    if (bus_if.bad_access !== 1'b0) begin
      n_fail++; $display("FAIL rst_bad: got %b want 0", bus_if.bad_access);
    end
    // Accesses during reset must be discarded
    drive(4'hf, 32'hbfaf_0000, 32'h0000_BEEF, 1'b0, 32'h0);
    item = sb_q.pop_front();
    step();
    drive(4'hf, 32'h200, 32'h0, 1'b0, 32'h0);
    item = sb_q.pop_front();
    step();
    reset = 1'b0;
    drive(4'h0, 32'h200, 32'h0, 1'b1, model[0]);
    #1;
    n_checks++;
    if (bus_if.rdata !== 32'h0) begin
      n_fail++; $display("FAIL post_rst_rdata: got %h want %h", bus_if.rdata, 32'h0);
    end
    step();
    item = sb_q.pop_front();
    idle();
    n_checks += 3;
    if (bus_if.rdata !== item[31:0]) begin
      n_fail++; $display("FAIL first_access: got %h want %h", bus_if.rdata, item[31:0]);
    end
    if (bus_if.led !== 16'h0) begin
      n_fail++; $display("FAIL rst_drop_led: got %h want %h", bus_if.led, 16'h0);
    end
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_empty: got %0d want 0", sb_q.size());
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus_if.en        = 1'b0;
    bus_if.wen       = 4'h0;
    bus_if.addr      = 32'h0;
    bus_if.wdata     = 32'h0;
    bus_if.switch_in = 8'h00;
    test_reset();
    test_ram_rw();
    test_read_first();
    test_back_to_back();
    test_config();
    test_timer();
    test_bad_access();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
